// File: rtl/clk_enable_gen_pkg.sv
// ---------------------------------------------------------------------------
// clk_enable_gen_pkg
// Shared types and constants for the clock-enable generator.
//   mode_e      : channel output mode (MODE_PULSE / MODE_SQUARE)
//   DEFAULT_DIV : divisor every channel holds after reset (period 51 cycles)
// ---------------------------------------------------------------------------
package clk_enable_gen_pkg;

    typedef enum logic {
        MODE_PULSE  = 1'b0,
        MODE_SQUARE = 1'b1
    } mode_e;

    localparam int DEFAULT_DIV = 50;

endpackage

// File: rtl/clk_enable_ch.sv
// ---------------------------------------------------------------------------
// clk_enable_ch
// One divider channel: counts 0..div, emits a one-cycle tick after cnt==div
// and drives clk_out as a pulse (== tick) or, when CLK_ENABLE_GEN_SQUARE_EN
// is defined, optionally a 50% square wave toggling on every wrap.
// A new divisor/mode is parked in a shadow and activated at the next wrap,
// on sync, or on the next cycle while the channel is disabled.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   en, sync    : run enable, phase restart
//   cfg_load    : accepted config for this channel (shadow load)
//   cfg_div     : new divisor
//   cfg_mode    : new mode (only with CLK_ENABLE_GEN_SQUARE_EN)
//   pending     : shadow holds a config not yet active
//   tick        : registered one-cycle enable pulse
//   clk_out     : registered output waveform
// ---------------------------------------------------------------------------
module clk_enable_ch
    import clk_enable_gen_pkg::*;
#(
    parameter int CNT_W   = 27,
    parameter int RST_DIV = 50
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             cfg_load,
    input  logic [CNT_W-1:0] cfg_div,
`ifdef CLK_ENABLE_GEN_SQUARE_EN
    input  logic             cfg_mode,
`endif
    output logic             pending,
    output logic             tick,
    output logic             clk_out
);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] div_reg;
    logic [CNT_W-1:0] pend_div_reg;
    logic             pending_reg;
    logic             tick_reg;
    logic             wrap;

    assign wrap = (cnt_reg == div_reg);

`ifdef CLK_ENABLE_GEN_SQUARE_EN
    mode_e mode_reg;
    mode_e pend_mode_reg;
    mode_e next_mode;
    logic  mode_change;
    logic  clk_out_reg;

    // Mode that will be in force after the current wrap.
    assign next_mode   = pending_reg ? pend_mode_reg : mode_reg;
    assign mode_change = pending_reg && (pend_mode_reg != mode_reg);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg      <= '0;
            div_reg      <= CNT_W'(RST_DIV);
            pend_div_reg <= '0;
            pending_reg  <= 1'b0;
            tick_reg     <= 1'b0;
`ifdef CLK_ENABLE_GEN_SQUARE_EN
            mode_reg      <= MODE_PULSE;
            pend_mode_reg <= MODE_PULSE;
            clk_out_reg   <= 1'b0;
`endif
        end else begin
            // sync and disable restart the count and are the points (besides
            // a wrap) where a parked config may be activated.
            if (sync || !en || wrap) begin
                cnt_reg <= '0;
                if (pending_reg) begin
                    div_reg     <= pend_div_reg;
                    pending_reg <= 1'b0;
`ifdef CLK_ENABLE_GEN_SQUARE_EN
                    mode_reg    <= pend_mode_reg;
`endif
                end
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end

            tick_reg <= en && !sync && wrap;

`ifdef CLK_ENABLE_GEN_SQUARE_EN
            if (sync || !en) begin
                clk_out_reg <= 1'b0;
            end else if (wrap) begin
                if (mode_change)
                    clk_out_reg <= 1'b0;
                else if (next_mode == MODE_PULSE)
                    clk_out_reg <= 1'b1;
                else
                    clk_out_reg <= ~clk_out_reg;
            end else if (mode_reg == MODE_PULSE) begin
                clk_out_reg <= 1'b0;
            end
`endif

            // A load is only possible while nothing is pending, so it never
            // collides with the clear above.
            if (cfg_load) begin
                pend_div_reg  <= cfg_div;
                pending_reg   <= 1'b1;
`ifdef CLK_ENABLE_GEN_SQUARE_EN
                pend_mode_reg <= mode_e'(cfg_mode);
`endif
            end
        end
    end

    assign pending = pending_reg;
    assign tick    = tick_reg;
`ifdef CLK_ENABLE_GEN_SQUARE_EN
    assign clk_out = clk_out_reg;
`else
    assign clk_out = tick_reg;
`endif

endmodule

// File: rtl/clk_enable_gen.sv
// ---------------------------------------------------------------------------
// clk_enable_gen
// NUM_CH independent clock-enable dividers sharing one config port.
// Optional square-wave mode is built only when CLK_ENABLE_GEN_SQUARE_EN is
// defined; otherwise cfg_mode is ignored and clk_out equals tick.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   en[NUM_CH]          : per-channel run enable
//   sync                : restart all channels in phase
//   cfg_valid/cfg_ready : config handshake
//   cfg_ch              : target channel (values >= NUM_CH are discarded)
//   cfg_div, cfg_mode   : new divisor and mode (0 pulse, 1 square)
//   tick[NUM_CH]        : one-cycle enable pulses
//   clk_out[NUM_CH]     : output waveforms
// ---------------------------------------------------------------------------
module clk_enable_gen #(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 27,
    parameter int DEFAULT_DIV = clk_enable_gen_pkg::DEFAULT_DIV,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_mode,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out
);

    logic [NUM_CH-1:0] sel;
    logic [NUM_CH-1:0] pending;

    // An out-of-range cfg_ch selects no channel, so it is always ready and
    // the transfer is silently dropped.
    assign cfg_ready = ~|(sel & pending);

`ifndef CLK_ENABLE_GEN_SQUARE_EN
    logic unused_cfg_mode;
    assign unused_cfg_mode = cfg_mode;
`endif

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign sel[gi] = (cfg_ch == CH_W'(gi));

            clk_enable_ch #(
                .CNT_W   (CNT_W),
                .RST_DIV (DEFAULT_DIV)
            ) u_ch (
                .clk      (clk),
                .rst_n    (rst_n),
                .en       (en[gi]),
                .sync     (sync),
                .cfg_load (cfg_valid && cfg_ready && sel[gi]),
                .cfg_div  (cfg_div),
`ifdef CLK_ENABLE_GEN_SQUARE_EN
                .cfg_mode (cfg_mode),
`endif
                .pending  (pending[gi]),
                .tick     (tick[gi]),
                .clk_out  (clk_out[gi])
            );
        end
    endgenerate

endmodule
